uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver feeding a first-word-fall-through FIFO, with sticky line-error flags
//   clk, reset_n                     : system clock, asynchronous active-low reset
//   uart_DI                          : serial line, asynchronous to clk
//   uart_DO, uart_valid, uart_ready  : FIFO head word with valid/ready pop handshake
//   fifo_count                       : entries currently held (0..FIFO_DEPTH)
//   frame_err, parity_err, overrun_err : sticky error flags
//   clear_err                        : synchronous clear of all sticky flags
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 186,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter bit IDLE_LEVEL   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          uart_DI,
    output logic [DATA_BITS-1:0]          uart_DO,
    output logic                          uart_valid,
    input  logic                          uart_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    input  logic                          clear_err
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               st, nxt;
    logic                 sync1, rxs, armed, tick, done;
    logic                 par_bad, stop_bad, fbad, good, pop, push, full;
    logic [1:0]           fill;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wp, rp;

    // fill marks when rxs holds a real line sample rather than its reset value,
    // so a line held active across reset release cannot arm the receiver
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync1 <= IDLE_LEVEL;
            rxs   <= IDLE_LEVEL;
            fill  <= '0;
            armed <= 1'b0;
        end else begin
            sync1 <= uart_DI;
            rxs   <= sync1;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] && rxs == IDLE_LEVEL);
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) st <= IDLE;
        else st <= nxt;

    always_comb begin
        nxt  = st;
        done = 1'b0;
        tick = (st == START) ? (cnt == CW'(CLKS_PER_BIT / 2)) : (cnt == CW'(CLKS_PER_BIT - 1));
        case (st)
            IDLE:  if (armed && rxs != IDLE_LEVEL) nxt = START;
            START: if (tick) nxt = (rxs == IDLE_LEVEL) ? IDLE : DATA;
            DATA:  if (tick && bit_idx == 4'(DATA_BITS - 1)) nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (tick) nxt = STOP;
            STOP:  if (tick && bit_idx == 4'(STOP_BITS - 1)) begin
                nxt  = IDLE;
                done = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    // par_bad folds the parity sense in: odd parity is bad when the XOR is 0
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            cnt      <= (st == IDLE || nxt != st || tick) ? '0 : cnt + CW'(1);
            bit_idx  <= (nxt != st) ? '0 : (tick && (st == DATA || st == STOP)) ? bit_idx + 4'd1 : bit_idx;
            if (tick && st == DATA) shreg <= {rxs, shreg[DATA_BITS-1:1]};
            par_bad  <= (st == IDLE) ? 1'b0 : (tick && st == PAR) ? ^{shreg, rxs, (PARITY == 1)} : par_bad;
            stop_bad <= (st == IDLE) ? 1'b0 : (tick && st == STOP) ? (stop_bad | (rxs != IDLE_LEVEL)) : stop_bad;
        end

    assign fbad       = stop_bad | (rxs != IDLE_LEVEL);
    assign good       = done && !fbad && !par_bad;
    assign uart_valid = wp != rp;
    assign pop        = uart_valid && uart_ready;
    assign full       = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign push       = good && (!full || pop);
    assign fifo_count = wp - rp;
    assign uart_DO    = uart_valid ? mem[rp[AW-1:0]] : '0;

    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= shreg;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wp          <= '0;
            rp          <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            wp          <= wp + {{AW{1'b0}}, push};
            rp          <= rp + {{AW{1'b0}}, pop};
            frame_err   <= (done && fbad) | (frame_err & ~clear_err);
            parity_err  <= (done && !fbad && par_bad) | (parity_err & ~clear_err);
            overrun_err <= (good && full && !pop) | (overrun_err & ~clear_err);
        end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo in 8N1/depth-4, 7E1 and 8N2 configurations
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       clk = 1'b0, reset_n = 1'b0, clr = 1'b0;
    logic       di_a = 1'b1, di_b = 1'b1, di_c = 1'b1;
    logic       rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
    logic [7:0] do_a, do_c;
    logic [6:0] do_b;
    logic       val_a, val_b, val_c;
    logic [2:0] cnt_a;
    logic [4:0] cnt_b, cnt_c;
    logic       fe_a, pe_a, oe_a, fe_b, pe_b, oe_b, fe_c, pe_c, oe_c;
    int         n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .IDLE_LEVEL(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .uart_DI(di_a), .uart_DO(do_a), .uart_valid(val_a), .uart_ready(rdy_a),
        .fifo_count(cnt_a), .frame_err(fe_a), .parity_err(pe_a), .overrun_err(oe_a), .clear_err(clr));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .uart_DI(di_b), .uart_DO(do_b), .uart_valid(val_b), .uart_ready(rdy_b),
        .fifo_count(cnt_b), .frame_err(fe_b), .parity_err(pe_b), .overrun_err(oe_b), .clear_err(clr));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16), .IDLE_LEVEL(1'b1)) dut_c (
        .clk(clk), .reset_n(reset_n), .uart_DI(di_c), .uart_DO(do_c), .uart_valid(val_c), .uart_ready(rdy_c),
        .fifo_count(cnt_c), .frame_err(fe_c), .parity_err(pe_c), .overrun_err(oe_c), .clear_err(clr));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    // frame bits go out LSB first, one bit per CPB clocks; pop_at pulses rdy_a on that cycle
    task automatic send(input int k, input logic [15:0] frame, input int nbits, input int pop_at);
        for (int c = 0; c < nbits * CPB; c++) begin
            @(negedge clk);
            if (k == 0) di_a = frame[c / CPB];
            else if (k == 1) di_b = frame[c / CPB];
            else di_c = frame[c / CPB];
            if (c == pop_at) rdy_a = 1'b1;
            else if (c == pop_at + 1) rdy_a = 1'b0;
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_a();
        @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        wait_n(3);
        chk("rst_valid", 32'(val_a), 0);
        chk("rst_count", 32'(cnt_a), 0);
        chk("rst_do", 32'(do_a), 0);
        chk("rst_flags", 32'({fe_a, pe_a, oe_a}), 0);
        chk("rst_flags_bc", 32'({fe_b, pe_b, oe_b, fe_c, pe_c, oe_c}), 0);
        reset_n = 1'b1;
        wait_n(5);

        send(0, f8n1(8'hA5), 10, -1);
        send(0, f8n1(8'h3C), 10, -1);
        wait_n(4);
        chk("b2b_count", 32'(cnt_a), 2);
        chk("b2b_valid", 32'(val_a), 1);
        chk("b2b_head0", 32'(do_a), 'hA5);
        chk("b2b_flags", 32'({fe_a, pe_a, oe_a}), 0);
        wait_n(3);
        chk("b2b_hold", 32'(do_a), 'hA5);
        pop_a();
        chk("b2b_head1", 32'(do_a), 'h3C);
        chk("b2b_count1", 32'(cnt_a), 1);
        pop_a();
        chk("b2b_empty", 32'(val_a), 0);
        pop_a();
        chk("pop_on_empty", 32'(cnt_a), 0);

        for (int i = 1; i <= 5; i++) send(0, f8n1(8'(i)), 10, -1);
        wait_n(4);
        chk("ovr_count", 32'(cnt_a), 4);
        chk("ovr_flag", 32'(oe_a), 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_drain%0d", i), 32'(do_a), 32'(i));
            pop_a();
        end
        chk("ovr_drained", 32'(val_a), 0);
        pulse_clr();
        chk("ovr_clear", 32'(oe_a), 0);

        for (int i = 1; i <= 4; i++) send(0, f8n1(8'(i)), 10, -1);
        wait_n(4);
        chk("full_count", 32'(cnt_a), 4);
        send(0, f8n1(8'h05), 10, 155);
        wait_n(4);
        chk("popfull_count", 32'(cnt_a), 4);
        chk("popfull_ovr", 32'(oe_a), 0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("popfull_drain%0d", i), 32'(do_a), 32'(i));
            pop_a();
        end
        chk("popfull_empty", 32'(val_a), 0);

        @(negedge clk);
        di_a = 1'b0;
        wait_n(3);
        di_a = 1'b1;
        wait_n(40);
        chk("glitch_count", 32'(cnt_a), 0);
        chk("glitch_flags", 32'({fe_a, pe_a, oe_a}), 0);
        send(0, f8n1(8'h77), 10, -1);
        wait_n(4);
        chk("post_glitch_do", 32'(do_a), 'h77);
        chk("post_glitch_count", 32'(cnt_a), 1);

        send(1, {6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, -1);
        send(1, {6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, -1);
        wait_n(4);
        chk("par_count", 32'(cnt_b), 1);
        chk("par_do", 32'(do_b), 'h41);
        chk("par_err", 32'(pe_b), 1);
        chk("par_frame", 32'(fe_b), 0);

        send(2, {5'b0, 1'b1, 1'b1, 8'hC3, 1'b0}, 11, -1);
        send(2, {5'b0, 1'b0, 1'b1, 8'h96, 1'b0}, 11, -1);
        di_c = 1'b1;
        wait_n(40);
        chk("stop_count", 32'(cnt_c), 1);
        chk("stop_do", 32'(do_c), 'hC3);
        chk("stop_frame", 32'(fe_c), 1);
        chk("stop_par", 32'(pe_c), 0);
        pulse_clr();
        chk("clr_frame", 32'(fe_c), 0);
        chk("clr_par", 32'(pe_b), 0);

        @(negedge clk);
        di_a = 1'b0;
        wait_n(40);
        reset_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(cnt_a), 0);
        chk("async_rst_valid", 32'(val_a), 0);
        wait_n(3);
        reset_n = 1'b1;
        wait_n(250);
        chk("held_low_count", 32'(cnt_a), 0);
        chk("held_low_flags", 32'({fe_a, pe_a, oe_a}), 0);
        di_a = 1'b1;
        wait_n(20);
        send(0, f8n1(8'h5A), 10, -1);
        wait_n(4);
        chk("rearm_do", 32'(do_a), 'h5A);
        chk("rearm_count", 32'(cnt_a), 1);
        chk("rearm_flags", 32'({fe_a, pe_a, oe_a}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
